hilo_ctrl: RTL and testbench

- Sequencer and HI/LO result register pair that sits directly downstream of the Booth multiplier `mult` and controls it.
- On a control-unit request it drives `mult` through one operand load and a fixed number of iterations, then captures the multiplier's hi/lo outputs into architectural HI/LO registers.
- Also services MTHI/MTLO writes and exposes HI/LO to the datapath for MFHI/MFLO.
- Signals busy so the control unit stalls while a multiply is in flight.

---
 rtl/muldiv_pkg.sv | 14 +
 rtl/hilo_regs.sv | 50 +++++
 rtl/hilo_ctrl.sv | 90 +++++++++
 tb/tb_hilo_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencing slice.
// Holds the hilo_ctrl state encoding and the default mult iteration count.
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int MULT_CYCLES_DEF = 32;
  localparam int CNT_W_DEF       = 6;

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair.
// Ports: clk, rst_n (async low), we_hi/we_lo + wdata (MTHI/MTLO),
// cap + cap_hi/cap_lo (product capture), hi_o/lo_o (register values).
module hilo_regs (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_hi,
  input  logic        we_lo,
  input  logic [31:0] wdata,
  input  logic        cap,
  input  logic [31:0] cap_hi,
  input  logic [31:0] cap_lo,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Capture and MT writes never coincide (RUN vs IDLE);
  // capture wins anyway so a product is never lost.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    unique case (1'b1)
      cap: begin
        hi_d = cap_hi;
        lo_d = cap_lo;
      end
      default: begin
        if (we_hi) hi_d = wdata;
        if (we_lo) lo_d = wdata;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/hilo_ctrl.sv
// Sequencer for the Booth multiplier plus the HI/LO result registers.
// Ports: clk, reset (async low), mult_start, mthi/mtlo/wdata, mult_hi/mult_lo
// in; mult_rst, busy, done, hi_out, lo_out out.
module hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult_start,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic        mult_rst,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             cap;
  logic             idle;

  assign idle = (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    cap     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mult_start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_RUN;
        cnt_d   = CNT_W'(MULT_CYCLES);
      end
      ST_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cap     = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // mult is held in load/reset everywhere except RUN,
  // including the unused encoding.
  assign mult_rst = (state_q != ST_RUN);
  assign busy     = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign done     = done_q;

  hilo_regs u_regs (
    .clk    (clk),
    .rst_n  (reset),
    .we_hi  (idle & mthi),
    .we_lo  (idle & mtlo),
    .wdata  (wdata),
    .cap    (cap),
    .cap_hi (mult_hi),
    .cap_lo (mult_lo),
    .hi_o   (hi_out),
    .lo_o   (lo_out)
  );

endmodule

// File: tb/tb_hilo_ctrl.sv
// Scoreboard bench for hilo_ctrl with a behavioural mult model.
// Expected products and capture edges are queued at stimulus time.
module tb_hilo_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mult_start;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic        mult_rst;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  hilo_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .mult_start (mult_start),
    .mthi       (mthi),
    .mtlo       (mtlo),
    .wdata      (wdata),
    .mult_hi    (mult_hi),
    .mult_lo    (mult_lo),
    .mult_rst   (mult_rst),
    .busy       (busy),
    .done       (done),
    .hi_out     (hi_out),
    .lo_out     (lo_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // mult model: loads while mult_rst, product valid only
  // after 32 iteration edges; garbage before that.
  logic [31:0] op_a, op_b;
  logic [63:0] prod_q;
  int          iter = 0;
  always @(posedge clk) begin
    if (mult_rst) begin
      prod_q <= 64'(longint'($signed(op_a)) * longint'($signed(op_b)));
      iter   <= 0;
    end else if (iter < 100) begin
      iter <= iter + 1;
    end
  end
  assign mult_hi = (iter >= 32) ? prod_q[63:32] : 32'hBADC0DE0;
  assign mult_lo = (iter >= 32) ? prod_q[31:0]  : 32'hBADC0DE1;

  typedef struct {
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse must match the head of the scoreboard.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset && done) begin
      chk("done_single", 64'(prev_done), 64'd0);
      chk("busy_at_done", 64'(busy), 64'd0);
      if (sb.size() == 0) begin
        chk("spurious_done", 64'(cyc), 64'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("done_edge", 64'(cyc), 64'(e.cyc));
        chk("hi_cap", 64'(hi_out), 64'(e.hi));
        chk("lo_cap", 64'(lo_out), 64'(e.lo));
      end
    end
    prev_done = done;
  end

  // Called just after a negedge: E0 is the next posedge.
  task automatic start_mul(logic [31:0] a, logic [31:0] b,
                           logic [31:0] eh, logic [31:0] el);
    exp_t e;
    op_a       = a;
    op_b       = b;
    mult_start = 1'b1;
    e.cyc = cyc + 1 + 34;
    e.hi  = eh;
    e.lo  = el;
    sb.push_back(e);
    @(negedge clk);
    mult_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int n;
    reset      = 1'b0;
    mult_start = 1'b0;
    mthi       = 1'b0;
    mtlo       = 1'b0;
    wdata      = '0;
    op_a       = '0;
    op_b       = '0;
    idle_cycles(3);
    chk("rst_hi", 64'(hi_out), 64'd0);
    chk("rst_lo", 64'(lo_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_mult_rst", 64'(mult_rst), 64'd1);
    reset = 1'b1;
    idle_cycles(2);

    // basic multiply, with LOAD/RUN output checks
    start_mul(32'd7, 32'd6, 32'h0, 32'h2A);
    chk("load_busy", 64'(busy), 64'd1);
    chk("load_mult_rst", 64'(mult_rst), 64'd1);
    @(negedge clk);
    chk("run_busy", 64'(busy), 64'd1);
    chk("run_mult_rst", 64'(mult_rst), 64'd0);
    wait_idle();

    // negative product
    start_mul(-32'sd3, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    wait_idle();

    // MTHI / MTLO / both
    wdata = 32'hDEADBEEF;
    mthi  = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    chk("mthi_hi", 64'(hi_out), 64'hDEADBEEF);
    chk("mthi_lo", 64'(lo_out), 64'hFFFFFFF1);
    wdata = 32'h12345678;
    mtlo  = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo_lo", 64'(lo_out), 64'h12345678);
    chk("mtlo_hi", 64'(hi_out), 64'hDEADBEEF);
    wdata = 32'hA5A5A5A5;
    mthi  = 1'b1;
    mtlo  = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    chk("mtboth_hi", 64'(hi_out), 64'hA5A5A5A5);
    chk("mtboth_lo", 64'(lo_out), 64'hA5A5A5A5);

    // busy blocking: dropped mthi and dropped second start
    start_mul(32'h00010000, 32'h00010000, 32'h1, 32'h0);
    idle_cycles(5);
    wdata = 32'hFFFFFFFF;
    mthi  = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    @(negedge clk);
    chk("busy_mthi_hi", 64'(hi_out), 64'hA5A5A5A5);
    op_a       = 32'd9;
    mult_start = 1'b1;
    @(negedge clk);
    mult_start = 1'b0;
    op_a       = 32'h00010000;
    wait_idle();
    idle_cycles(40);

    // start and mthi together in IDLE
    wdata = 32'h11111111;
    mthi  = 1'b1;
    start_mul(32'd2, 32'd3, 32'h0, 32'h6);
    mthi = 1'b0;
    chk("start_mthi_hi", 64'(hi_out), 64'h11111111);
    wait_idle();

    // reset mid-RUN
    start_mul(32'd100, 32'd100, 32'h0, 32'd10000);
    idle_cycles(14);
    sb.delete();
    reset = 1'b0;
    #1;
    chk("mid_rst_hi", 64'(hi_out), 64'd0);
    chk("mid_rst_lo", 64'(lo_out), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_mult_rst", 64'(mult_rst), 64'd1);
    idle_cycles(2);
    reset = 1'b1;
    idle_cycles(2);
    start_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1);
    wait_idle();

    // back-to-back: restart in the done cycle
    start_mul(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", 64'(done), 64'd1);
    start_mul(32'h80000000, 32'd2, 32'hFFFFFFFF, 32'h00000000);
    wait_idle();
    idle_cycles(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
